// File: rtl/k005290_seq_if.sv
// Bus between the video timing generator and k005290_seq: pixel enable, HCNT,
// per-layer scroll/flip/enable controls and the K005290 mode/flip/active outputs.
interface k005290_seq_if;
    logic       i_EMU_CLK6MPCEN_n;
    logic [8:0] i_HCNT;
    logic [2:0] i_A_SCROLLX;
    logic [2:0] i_B_SCROLLX;
    logic       i_A_FLIP_REQ;
    logic       i_B_FLIP_REQ;
    logic       i_A_EN;
    logic       i_B_EN;
    logic [1:0] o_A_MODE;
    logic [1:0] o_B_MODE;
    logic       o_A_FLIP;
    logic       o_B_FLIP;
    logic       o_A_ACTIVE;
    logic       o_B_ACTIVE;

    modport master (
        output i_EMU_CLK6MPCEN_n, i_HCNT, i_A_SCROLLX, i_B_SCROLLX,
               i_A_FLIP_REQ, i_B_FLIP_REQ, i_A_EN, i_B_EN,
        input  o_A_MODE, o_B_MODE, o_A_FLIP, o_B_FLIP, o_A_ACTIVE, o_B_ACTIVE
    );

    modport slave (
        input  i_EMU_CLK6MPCEN_n, i_HCNT, i_A_SCROLLX, i_B_SCROLLX,
               i_A_FLIP_REQ, i_B_FLIP_REQ, i_A_EN, i_B_EN,
        output o_A_MODE, o_B_MODE, o_A_FLIP, o_B_FLIP, o_A_ACTIVE, o_B_ACTIVE
    );
endinterface

// File: rtl/k005290_seq.sv
// Per-layer K005290 shift-register sequencer (prime / load+shift / drain / hold).
// Optional BUBSYS_LAYER_DISABLE_EN: i_x_EN = 0 blanks a layer without disturbing its sequencing.
module k005290_seq #(
    parameter logic [8:0] HACT_START = 9'd136,
    parameter logic [8:0] HACT_END   = 9'd392
) (
    input  logic          i_EMU_MCLK,
    input  logic          i_EMU_MRST,
    k005290_seq_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_BLANK  = 2'd0,
        ST_PRIME  = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    localparam logic [8:0] PRIME_AT  = HACT_START - 9'd16;
    localparam logic [8:0] ACTIVE_AT = HACT_START - 9'd1;
    localparam logic [8:0] DRAIN_AT  = HACT_END - 9'd1;

    logic pix_en_s;
    assign pix_en_s = ~bus.i_EMU_CLK6MPCEN_n;

`ifndef BUBSYS_LAYER_DISABLE_EN
    logic unused_en_s;
    assign unused_en_s = bus.i_A_EN ^ bus.i_B_EN;
`endif

    for (genvar g = 0; g < 2; g++) begin : g_layer
        logic [2:0] scrollx_s;
        logic       flip_req_s;
        logic       layer_en_s;
        state_t     state_r, state_s;
        logic [2:0] scroll_r, scroll_s, drain_r, drain_s, phase_s;
        logic       flip_r, flip_s, seq_s;
        logic [1:0] shift_mode_s, seq_mode_s, mode_r, mode_s;
        logic       flip_out_r, flip_out_s, active_r, active_s;

        if (g == 0) begin : g_a
            assign scrollx_s      = bus.i_A_SCROLLX;
            assign flip_req_s     = bus.i_A_FLIP_REQ;
`ifdef BUBSYS_LAYER_DISABLE_EN
            assign layer_en_s     = bus.i_A_EN;
`else
            assign layer_en_s     = 1'b1;
`endif
            assign bus.o_A_MODE   = mode_r;
            assign bus.o_A_FLIP   = flip_out_r;
            assign bus.o_A_ACTIVE = active_r;
        end else begin : g_b
            assign scrollx_s      = bus.i_B_SCROLLX;
            assign flip_req_s     = bus.i_B_FLIP_REQ;
`ifdef BUBSYS_LAYER_DISABLE_EN
            assign layer_en_s     = bus.i_B_EN;
`else
            assign layer_en_s     = 1'b1;
`endif
            assign bus.o_B_MODE   = mode_r;
            assign bus.o_B_FLIP   = flip_out_r;
            assign bus.o_B_ACTIVE = active_r;
        end

        // Next state, scroll/flip latches and the mode issued for the sampled HCNT
        always_comb begin
            state_s      = state_r;
            scroll_s     = scroll_r;
            drain_s      = drain_r;
            flip_s       = flip_r;
            phase_s      = scroll_r;
            seq_s        = 1'b0;
            shift_mode_s = flip_r ? 2'b01 : 2'b10;
            seq_mode_s   = 2'b00;
            mode_s       = 2'b00;
            flip_out_s   = flip_r;
            active_s     = 1'b0;
            case (state_r)
                ST_BLANK: begin
                    // The entry enable already follows the newly sampled scroll phase.
                    if (bus.i_HCNT == PRIME_AT) begin
                        state_s  = ST_PRIME;
                        scroll_s = scrollx_s;
                        phase_s  = scrollx_s;
                        seq_s    = 1'b1;
                    end else begin
                        state_s  = ST_BLANK;
                    end
                end
                ST_PRIME: begin
                    seq_s = 1'b1;
                    if (bus.i_HCNT == ACTIVE_AT) begin
                        state_s = ST_ACTIVE;
                    end else begin
                        state_s = ST_PRIME;
                    end
                end
                ST_ACTIVE: begin
                    seq_s = 1'b1;
                    if (bus.i_HCNT == DRAIN_AT) begin
                        state_s = ST_DRAIN;
                        drain_s = 3'd0;
                    end else begin
                        state_s = ST_ACTIVE;
                    end
                end
                ST_DRAIN: begin
                    drain_s = drain_r + 3'd1;
                    if (drain_r == 3'd7) begin
                        state_s = ST_BLANK;
                    end else begin
                        state_s = ST_DRAIN;
                    end
                end
                default: begin
                    state_s = ST_BLANK;
                end
            endcase

            if (seq_s && (bus.i_HCNT[2:0] == phase_s)) begin
                seq_mode_s = 2'b11;
                flip_s     = flip_req_s;
            end else if (seq_s || (state_r == ST_DRAIN)) begin
                seq_mode_s = shift_mode_s;
            end else begin
                seq_mode_s = 2'b00;
            end

            mode_s     = seq_mode_s;
            flip_out_s = flip_s;
            if (!layer_en_s && (seq_mode_s != 2'b00)) begin
                mode_s     = 2'b01;
                flip_out_s = 1'b0;
            end else begin
                mode_s     = seq_mode_s;
            end

            active_s = (state_s == ST_PRIME) || (state_s == ST_ACTIVE);
        end

        // State and output registers, advancing only on pixel enables
        always_ff @(posedge i_EMU_MCLK or posedge i_EMU_MRST) begin
            if (i_EMU_MRST) begin
                state_r    <= ST_BLANK;
                scroll_r   <= 3'd0;
                drain_r    <= 3'd0;
                flip_r     <= 1'b0;
                mode_r     <= 2'b00;
                flip_out_r <= 1'b0;
                active_r   <= 1'b0;
            end else if (pix_en_s) begin
                state_r    <= state_s;
                scroll_r   <= scroll_s;
                drain_r    <= drain_s;
                flip_r     <= flip_s;
                mode_r     <= mode_s;
                flip_out_r <= flip_out_s;
                active_r   <= active_s;
            end
        end
    end
endmodule

// File: tb/tb_k005290_seq.sv
// Directed bench for k005290_seq: expected outputs are queued per enable and
// popped after the registered edge, plus per-line load counts.
module tb_k005290_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    int   cur_h    = 0;
    int   loads_a  = 0;
    int   loads_b  = 0;

    typedef struct packed {
        logic [1:0] ma;
        logic [1:0] mb;
        logic       fa;
        logic       fb;
        logic       aa;
        logic       ab;
    } exp_t;

    exp_t sbq[$];

    // line phase per layer: 0 blank, 1 prime/active, 2 drain
    int   m_ph   [2];
    int   m_scr  [2];
    logic m_flip [2];

    k005290_seq_if bus ();

    k005290_seq dut (
        .i_EMU_MCLK (clk),
        .i_EMU_MRST (rst),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b hcnt=%0d", tag, obs, exp_v, cur_h);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    function automatic void model_step(input int l, input int h, input logic [2:0] scr,
                                       input logic req, input logic en,
                                       output logic [1:0] m, output logic f, output logic a);
        m = 2'b00;
        a = 1'b0;
        if (m_ph[l] == 0 && h == 120) begin
            m_ph[l]  = 1;
            m_scr[l] = int'(scr);
        end
        if (m_ph[l] == 1) begin
            if ((h % 8) == m_scr[l]) begin
                m         = 2'b11;
                m_flip[l] = req;
            end else begin
                m = m_flip[l] ? 2'b01 : 2'b10;
            end
            if (h == 391) m_ph[l] = 2;
            else          a = 1'b1;
        end else if (m_ph[l] == 2) begin
            m = m_flip[l] ? 2'b01 : 2'b10;
            if (h == 399) m_ph[l] = 0;
        end
        f = m_flip[l];
`ifdef BUBSYS_LAYER_DISABLE_EN
        if (!en && m != 2'b00) begin
            m = 2'b01;
            f = 1'b0;
        end
`else
        if (en === 1'bx) f = f;
`endif
    endfunction

    task automatic compare_pop(input string tag);
        exp_t e;
        e = sbq.pop_front();
        chk({tag, "_mode_a"},   bus.o_A_MODE,              e.ma);
        chk({tag, "_mode_b"},   bus.o_B_MODE,              e.mb);
        chk({tag, "_flip_a"},   {1'b0, bus.o_A_FLIP},      {1'b0, e.fa});
        chk({tag, "_flip_b"},   {1'b0, bus.o_B_FLIP},      {1'b0, e.fb});
        chk({tag, "_active_a"}, {1'b0, bus.o_A_ACTIVE},    {1'b0, e.aa});
        chk({tag, "_active_b"}, {1'b0, bus.o_B_ACTIVE},    {1'b0, e.ab});
    endtask

    // one enable edge followed by one idle edge (enable every 2nd MCLK)
    task automatic pix(input int h);
        exp_t e;
        logic [1:0] ma, mb;
        logic fa, fb, aa, ab;
        cur_h = h;
        bus.i_HCNT = 9'(h);
        bus.i_EMU_CLK6MPCEN_n = 1'b0;
        model_step(0, h, bus.i_A_SCROLLX, bus.i_A_FLIP_REQ, bus.i_A_EN, ma, fa, aa);
        model_step(1, h, bus.i_B_SCROLLX, bus.i_B_FLIP_REQ, bus.i_B_EN, mb, fb, ab);
        e = '{ma: ma, mb: mb, fa: fa, fb: fb, aa: aa, ab: ab};
        sbq.push_back(e);
        @(posedge clk);
        #1;
        bus.i_EMU_CLK6MPCEN_n = 1'b1;
        compare_pop("en");
        if (bus.o_A_MODE == 2'b11) loads_a++;
        if (bus.o_B_MODE == 2'b11) loads_b++;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        compare_pop("hold");
    endtask

    task automatic do_reset();
        exp_t z;
        z = '0;
        rst = 1'b1;
        #1;
        sbq.push_back(z);
        compare_pop("reset");
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int l = 0; l < 2; l++) begin
            m_ph[l]   = 0;
            m_scr[l]  = 0;
            m_flip[l] = 1'b0;
        end
    endtask

    initial begin
        bus.i_EMU_CLK6MPCEN_n = 1'b1;
        bus.i_HCNT       = 9'd0;
        bus.i_A_SCROLLX  = 3'd0;
        bus.i_B_SCROLLX  = 3'd0;
        bus.i_A_FLIP_REQ = 1'b0;
        bus.i_B_FLIP_REQ = 1'b0;
        bus.i_A_EN       = 1'b1;
        bus.i_B_EN       = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // line 1: scroll 0, no flip
        loads_a = 0; loads_b = 0;
        for (int h = 0; h < 512; h++) pix(h);
        chk_int("loads_a_line1", loads_a, 34);
        chk_int("loads_b_line1", loads_b, 34);

        // line 2: A scroll 5, B scroll 2
        bus.i_A_SCROLLX = 3'd5;
        bus.i_B_SCROLLX = 3'd2;
        loads_a = 0; loads_b = 0;
        for (int h = 0; h < 512; h++) pix(h);
        chk_int("loads_a_line2", loads_a, 34);
        chk_int("loads_b_line2", loads_b, 34);

        // line 3: A scroll 3 -> 6 mid-line, B scroll 0 with flip request at 203
        bus.i_A_SCROLLX = 3'd3;
        bus.i_B_SCROLLX = 3'd0;
        loads_a = 0; loads_b = 0;
        for (int h = 0; h < 512; h++) begin
            if (h == 200) bus.i_A_SCROLLX = 3'd6;
            if (h == 203) bus.i_B_FLIP_REQ = 1'b1;
            pix(h);
        end
        chk_int("loads_a_line3", loads_a, 34);
        chk_int("loads_b_line3", loads_b, 34);

        // line 4: A now at phase 6, B flipped; reset mid-line at 250
        for (int h = 0; h < 512; h++) begin
            if (h == 250) do_reset();
            pix(h);
        end

        // line 5: A scroll 0 with flip request at 203, B disabled over 150..199
        bus.i_A_SCROLLX  = 3'd0;
        bus.i_B_FLIP_REQ = 1'b0;
        loads_a = 0;
        for (int h = 0; h < 512; h++) begin
            if (h == 150) bus.i_B_EN = 1'b0;
            if (h == 200) bus.i_B_EN = 1'b1;
            if (h == 203) bus.i_A_FLIP_REQ = 1'b1;
            pix(h);
        end
        chk_int("loads_a_line5", loads_a, 34);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/k005290_seq.md
# k005290_seq

Per-layer sequencer for the K005290 tilemap shift register pair. It drives the A/B mode and flip inputs from the horizontal pixel counter. Each line it primes the shift registers before active video, parallel-loads them every 8 pixels at a phase set by the layer's fine X scroll, and drains them after active video. During blanking it holds them. It sits between the video timing generator and the K005290 in the BubSys video path.

## Interface
Parameters:
- HACT_START, 9'd136, first HCNT value of active video
- HACT_END, 9'd392, first HCNT value after active video (HACT_END > HACT_START + 16)

Ports:
- i_EMU_MCLK  in  1  master clock; all state on posedge
- i_EMU_MRST  in  1  reset, asynchronous, active-high
- i_EMU_CLK6MPCEN_n  in  1  pixel clock enable, active-low; state advances only when low
- i_HCNT  in  9  pixel counter from timing generator, +1 per enable
- i_A_SCROLLX, i_B_SCROLLX  in  3  fine X scroll per layer
- i_A_FLIP_REQ, i_B_FLIP_REQ  in  1  requested horizontal flip per layer
- i_A_EN, i_B_EN  in  1  layer enable (used only with BUBSYS_LAYER_DISABLE_EN)
- o_A_MODE, o_B_MODE  out  2  K005290 mode: 00 hold, 10 shift normal, 01 shift flipped, 11 load
- o_A_FLIP, o_B_FLIP  out  1  K005290 flip inputs
- o_A_ACTIVE, o_B_ACTIVE  out  1  layer FSM in PRIME or ACTIVE

## Operation
- Layers A and B are identical and independent. Each has its own FSM, its own scroll and flip registers, and a 3-bit drain counter. Description below is per layer; "enable" means an MCLK edge with i_EMU_CLK6MPCEN_n low.
- FSM states:
  - BLANK: mode 00.
  - BLANK -> PRIME on sampled HCNT == HACT_START-16. On that enable, scroll_l <= SCROLLX.
  - PRIME and ACTIVE: load/shift.
  - PRIME -> ACTIVE on HCNT == HACT_START-1.
  - ACTIVE -> DRAIN on HCNT == HACT_END-1; drain counter <= 0.
  - DRAIN: shift only, never load, so zeros (transparent) fill the register. Counter +1 per enable.
  - DRAIN -> BLANK when counter == 7, i.e. exactly 8 drain enables.
- Load/shift rule in PRIME/ACTIVE:
  - If HCNT[2:0] == scroll_l, issue mode 11 and set flip_l <= FLIP_REQ.
  - Otherwise issue mode 10 if flip_l == 0, or 01 if flip_l == 1.
- Scroll is sampled only at PRIME entry; mid-line SCROLLX changes take effect on the next line.
- Flip changes take effect only on a load cycle, never mid-tile. o_x_FLIP = flip_l.
- HCNT jump (resync) while in PRIME/ACTIVE with no matching end value: FSM stays until a matching value occurs. A reset is the only forced exit.
- Reset mid-line: all FSMs go to BLANK, modes 00, flips 0, scroll_l 0, drain counters 0. Normal sequencing resumes at the next HACT_START-16.

## Timing
- All outputs are registered. The decision uses the HCNT value sampled on enable edge N. The output is valid from edge N until edge N+1, during which the K005290 consumes it.
- Load period is exactly 8 enables in PRIME/ACTIVE, independent of scroll.
- PRIME is 16 enables, giving at least two loads before active video.
- Output pixels appear at the K005290 output 4 enables (A) or 1 enable (B) after the shift. Compensating for this is the mixer's job.
- Outputs do not change while the enable is high.
- Reset values: o_A_MODE = o_B_MODE = 00, o_A_FLIP = o_B_FLIP = 0, o_A_ACTIVE = o_B_ACTIVE = 0.

## Configuration
- BUBSYS_LAYER_DISABLE_EN defined:
  - While i_x_EN = 0 and the FSM is not in BLANK: o_x_MODE = 01 and o_x_FLIP = 0, which makes the K005290 output black/transparent.
  - FSM, scroll and flip registers keep sequencing normally, so re-enabling mid-line is tile-aligned.
- Not defined: i_A_EN and i_B_EN are ignored; behaviour is as if both are 1.

## Test plan
- Reset released, HCNT sweeps 0..511 with enable every 2nd MCLK, scroll 0, no flip -> mode 00 through HCNT 119. Mode 11 at HCNT 120, 128, ..., 384, 10 elsewhere in 120..391. Mode 10 for HCNT 392..399, then 00.
- A scroll 5, B scroll 2 -> A loads at HCNT[2:0] = 5 (125, 133, ...), B loads at HCNT[2:0] = 2 (122, 130, ...). Exactly 34 loads per layer per line.
- Change A_SCROLLX 3 -> 6 at HCNT 200 -> line unchanged (loads at ...3); next line loads at ...6 starting at 126.
- Raise A_FLIP_REQ at HCNT 203, scroll 0 -> o_A_FLIP rises at the load for HCNT 208, mode 01 from HCNT 209; no 01 before.
- Assert i_EMU_MRST at HCNT 250 for 3 MCLKs -> all outputs 0 asynchronously. Modes stay 00 until HCNT 120 of the next line.
- With BUBSYS_LAYER_DISABLE_EN, B_EN = 0 over HCNT 150..199 -> o_B_MODE = 01 and o_B_FLIP = 0 there. Loads resume on schedule at HCNT 200 (scroll 0).
